servo_driver: RTL and testbench
===============================

Name: servo_driver

Overview:
- Converts a commanded joint angle (degrees) from fsm_controller into a 50 Hz hobby-servo pulse train. One instance each drives shoulder_servo and elbow_servo.
- Applies per-frame slew limiting so large target jumps (keyboard steps, noisy ultrasonic distance) do not slam the arm.
- Sits directly downstream of the angle computation, between it and the servo pins.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- FRAME_HZ, 50, servo frame rate.
- MIN_PULSE_US, 1000, pulse width at 0 degrees.
- MAX_PULSE_US, 2000, pulse width at ANGLE_MAX.
- ANGLE_MAX, 180, largest legal angle; larger commands are clamped to this value.
- HOME_ANGLE, 90, angle held after reset.
- SLEW_DEG, 2, maximum change of the current angle per frame (must be at least 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  drive pulses when high; sampled only at frame boundaries.
- angle  in  8  target angle in degrees, unsigned.
- angle_valid  in  1  single-cycle strobe; latch angle as the new target.
- servo_out  out  1  PWM output to the servo pin.
- current_angle  out  8  angle currently being driven, after slew limiting.
- busy  out  1  high while current_angle differs from the target.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Derived constants:
  - FRAME_CYCLES = CLK_HZ/FRAME_HZ.
  - MIN_CYCLES = MIN_PULSE_US*(CLK_HZ/1_000_000).
  - STEP_CYCLES = ((MAX_PULSE_US-MIN_PULSE_US)*(CLK_HZ/1_000_000))/ANGLE_MAX, truncated.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps to 0.
  - Free-running from reset, independent of enable.
  - frame_tick is asserted when the count equals FRAME_CYCLES-1.
- Target register:
  - On angle_valid, target <= min(angle, ANGLE_MAX).
  - A strobe with no change to the value is harmless.
- Slew update, performed on the frame_tick cycle:
  - If target > current: current += min(SLEW_DEG, target-current).
  - If target < current: current -= min(SLEW_DEG, current-target).
  - The update uses the target value registered before this cycle. An angle_valid arriving on the frame_tick cycle takes effect at the next frame.
- Pulse width is computed at the same edge: pulse_cycles <= MIN_CYCLES + new_current*STEP_CYCLES. Use a constant multiply, no division in the datapath.
- FSM (states in package):
  - IDLE: servo_out=0. At frame_tick with enable=1, go to PULSE; the new frame starts at count 0.
  - PULSE: servo_out=1. Go to HOLD when count == pulse_cycles-1; servo_out falls on the next cycle, giving exactly pulse_cycles high cycles.
  - HOLD: servo_out=0. At frame_tick, go to PULSE if enable=1, otherwise IDLE.
- Disable mid-frame: the current pulse completes at full width and no truncated pulses are produced. enable is re-checked only at frame_tick.
- busy = (current_angle != target), combinational from registers.
- Reset values:
  - servo_out=0, state=IDLE, count=0.
  - current_angle=target=HOME_ANGLE.
  - pulse_cycles=MIN_CYCLES+HOME_ANGLE*STEP_CYCLES.
  - frame_tick=0, busy=0.
- Reset asserted mid-pulse drops servo_out immediately, without waiting for a clock.
- Widths:
  - Counter is $clog2(FRAME_CYCLES) bits.
  - Slew arithmetic uses 9-bit signed differences, so there is no underflow near 0 or overflow near ANGLE_MAX.

Decomposition:
- servo_pkg holds:
  - the state enum (IDLE, PULSE, HOLD);
  - the derived-constant functions for FRAME_CYCLES, MIN_CYCLES and STEP_CYCLES;
  - the angle width localparam.
- One sub-module, servo_slew: a registered target/current slew limiter with clamp. It has clk, reset, angle, angle_valid, step strobe (= frame_tick), current_angle and busy.
- servo_driver keeps the frame counter, the pulse_cycles register and the FSM.

Test Plan (sim params: CLK_HZ=1_000_000, so FRAME_CYCLES=20000, MIN_CYCLES=1000, STEP_CYCLES=5):
- Reset with enable=0 -> servo_out=0, current_angle=90, busy=0, frame_tick every 20000 cycles, no pulses.
- Raise enable mid-frame -> first rising edge at the next frame start; high for exactly 1450 cycles; period 20000.
- angle=100 pulsed once -> busy=1; current_angle goes 92, 94, 96, 98, 100 on successive frame_ticks; busy=0 after the fifth; pulse width 1500.
- angle=250 -> target clamped to 180; steady-state pulse 1900 cycles. Then angle=0 -> ramps down by 2 per frame to 0; pulse width 1000; no wrap below 0.
- angle_valid coincident with frame_tick -> that frame's step uses the old target; the new target moves current_angle from the following frame.
- Drop enable 300 cycles into a pulse -> pulse still lasts 1450 cycles; servo_out stays 0 thereafter. Assert reset mid-pulse -> servo_out=0 in the same cycle and current_angle=90.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and elaboration-time helpers for the hobby-servo pulse driver.
// Holds the output FSM state encoding and the frame/pulse cycle-count derivations.
// Nothing here generates logic on its own; it is imported by servo_slew and servo_driver.
package servo_pkg;

  // Angles are whole degrees carried on an 8-bit unsigned bus.
  localparam int ANGLE_W = 8;
  // One extra bit so target-current can be represented signed without wrap.
  localparam int DIFF_W  = ANGLE_W + 1;

  // Output pulse FSM: IDLE while disabled, PULSE while the pin is high,
  // HOLD for the low remainder of an enabled frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clock cycles in one servo frame.
  function automatic int frame_cycles(input int clk_hz, input int frame_hz);
    return clk_hz / frame_hz;
  endfunction

  // Clock cycles of the 0-degree pulse.
  function automatic int min_cycles(input int clk_hz, input int min_pulse_us);
    return min_pulse_us * (clk_hz / 1_000_000);
  endfunction

  // Clock cycles added per degree, truncated so the datapath needs only a constant multiply.
  function automatic int step_cycles(input int clk_hz, input int min_pulse_us,
                                     input int max_pulse_us, input int angle_max);
    return ((max_pulse_us - min_pulse_us) * (clk_hz / 1_000_000)) / angle_max;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// Target register with clamp plus a per-step slew limiter for the driven angle.
// current_angle moves on the step strobe only; next_angle is the value it will take at that edge.
// No backpressure: every angle_valid strobe overwrites the target immediately.
module servo_slew
  import servo_pkg::*;
#(
  parameter int ANGLE_MAX  = 180,
  parameter int HOME_ANGLE = 90,
  parameter int SLEW_DEG   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_valid,
  input  logic               step,
  output logic [ANGLE_W-1:0] current_angle,
  output logic [ANGLE_W-1:0] next_angle,
  output logic               busy
);

  localparam logic [ANGLE_W-1:0]       AMAX   = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0]       HOME   = ANGLE_W'(HOME_ANGLE);
  localparam logic [ANGLE_W-1:0]       SLEW_U = ANGLE_W'(SLEW_DEG);
  localparam logic signed [DIFF_W-1:0] SLEW_S = DIFF_W'(SLEW_DEG);

  logic [ANGLE_W-1:0]       target;
  logic signed [DIFF_W-1:0] diff;

  // Latch a new target, clamping out-of-range commands to the largest legal angle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= HOME;
    end else if (angle_valid) begin
      target <= (angle > AMAX) ? AMAX : angle;
    end
  end

  // Signed distance to the target, then the limited move toward it.
  always_comb begin
    diff       = $signed({1'b0, target}) - $signed({1'b0, current_angle});
    next_angle = current_angle;
    if (diff > SLEW_S) begin
      next_angle = current_angle + SLEW_U;
    end else if (diff < -SLEW_S) begin
      next_angle = current_angle - SLEW_U;
    end else begin
      next_angle = target;
    end
  end

  // Commit the limited move once per step strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_angle <= HOME;
    end else if (step) begin
      current_angle <= next_angle;
    end
  end

  // Still travelling while the driven angle has not reached the target.
  always_comb begin
    busy = (current_angle != target);
  end

endmodule

// File: rtl/servo_driver.sv
// Hobby-servo driver: slew-limited angle to a fixed-rate pulse train of MIN+angle*STEP cycles.
// Pulse starts on the first cycle of a frame; width and angle update at the frame_tick edge.
// enable is only honoured at frame boundaries, so pulses are never truncated or started mid-frame.
module servo_driver
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FRAME_HZ     = 50,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int ANGLE_MAX    = 180,
  parameter int HOME_ANGLE   = 90,
  parameter int SLEW_DEG     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_valid,
  output logic               servo_out,
  output logic [ANGLE_W-1:0] current_angle,
  output logic               busy,
  output logic               frame_tick
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_HZ, FRAME_HZ);
  localparam int MIN_CYCLES   = min_cycles(CLK_HZ, MIN_PULSE_US);
  localparam int STEP_CYCLES  = step_cycles(CLK_HZ, MIN_PULSE_US, MAX_PULSE_US, ANGLE_MAX);
  localparam int CNT_W        = $clog2(FRAME_CYCLES);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] HOME_PULSE = CNT_W'(MIN_CYCLES + HOME_ANGLE * STEP_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   pulse_cycles;
  logic [CNT_W-1:0]   pulse_next;
  logic [ANGLE_W-1:0] next_angle;
  logic               pulse_end;
  state_t             state;
  state_t             state_next;

  servo_slew #(
    .ANGLE_MAX  (ANGLE_MAX),
    .HOME_ANGLE (HOME_ANGLE),
    .SLEW_DEG   (SLEW_DEG)
  ) u_slew (
    .clk           (clk),
    .reset         (reset),
    .angle         (angle),
    .angle_valid   (angle_valid),
    .step          (frame_tick),
    .current_angle (current_angle),
    .next_angle    (next_angle),
    .busy          (busy)
  );

  // Free-running frame counter; runs whether or not pulses are enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (frame_tick) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  // Frame boundary, pulse-end compare and the width of the pulse for the slewed angle.
  always_comb begin
    frame_tick = (count == LAST_CNT);
    pulse_end  = (count == (pulse_cycles - ONE));
    pulse_next = MIN_C + CNT_W'(next_angle) * STEP_C;
  end

  // Pulse width follows the angle that becomes current at the same frame edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cycles <= HOME_PULSE;
    end else if (frame_tick) begin
      pulse_cycles <= pulse_next;
    end
  end

  // FSM state register; reset forces IDLE so the pin drops without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and pin drive.
  always_comb begin
    state_next = state;
    servo_out  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick && enable) begin
          state_next = PULSE;
        end
      end
      PULSE: begin
        servo_out = 1'b1;
        if (pulse_end) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (frame_tick) begin
          state_next = enable ? PULSE : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_servo_driver.sv
// Self-checking bench for servo_driver using a scaled-down clock so many frames fit in a short run.
// Frame = 500 cycles, 0-degree pulse = 40 cycles, 2 cycles per degree, slew 3 degrees per frame.
// A frame-level reference model (target, current angle) is stepped once per observed frame_tick.
module tb_servo_driver;

  localparam int FRAME = 500;   // 1 MHz / 2 kHz
  localparam int MINC  = 40;    // 40 us at 1 MHz
  localparam int STEP  = 2;     // (420-40)/180 truncated
  localparam int AMAX  = 180;
  localparam int HOME  = 90;
  localparam int SLEW  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] angle;
  logic       angle_valid;
  logic       servo_out;
  logic [7:0] current_angle;
  logic       busy;
  logic       frame_tick;

  int compared   = 0;
  int mismatched = 0;
  int m_target;
  int m_current;

  servo_driver #(
    .CLK_HZ       (1_000_000),
    .FRAME_HZ     (2000),
    .MIN_PULSE_US (40),
    .MAX_PULSE_US (420),
    .ANGLE_MAX    (AMAX),
    .HOME_ANGLE   (HOME),
    .SLEW_DEG     (SLEW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .angle         (angle),
    .angle_valid   (angle_valid),
    .servo_out     (servo_out),
    .current_angle (current_angle),
    .busy          (busy),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int pulse_of(input int a);
    return MINC + a * STEP;
  endfunction

  function automatic int clamp(input int a);
    return (a > AMAX) ? AMAX : a;
  endfunction

  // One frame of motion: move toward the target by at most SLEW degrees.
  function automatic int slew_ref(input int cur, input int tgt);
    int gap;
    if (tgt > cur) begin
      gap = tgt - cur;
      return cur + ((gap < SLEW) ? gap : SLEW);
    end
    if (tgt < cur) begin
      gap = cur - tgt;
      return cur - ((gap < SLEW) ? gap : SLEW);
    end
    return cur;
  endfunction

  // Advance to just after the next frame_tick edge and step the model.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL frame_tick_timeout: none within %0d cycles, required one", FRAME + 2);
    end
    @(posedge clk);
    #1;
    m_current = slew_ref(m_current, m_target);
  endtask

  // High-cycle count of a pulse that is already under way (called right after a tick).
  task automatic measure_width(output int w);
    w = 0;
    for (int i = 0; i < FRAME - 20; i++) begin
      @(negedge clk);
      if (servo_out === 1'b1) w++;
      else break;
    end
  endtask

  task automatic strobe(input int a);
    @(negedge clk);
    angle       = 8'(a);
    angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
    m_target    = clamp(a);
  endtask

  // Step frame by frame until the model converges (plus extra frames), checking angle, busy and width.
  task automatic run_ramp(input string tag, input int extra);
    int left;
    int w;
    int guard;
    left  = extra;
    guard = 0;
    while (guard < 200) begin
      if (m_current == m_target) begin
        if (left == 0) break;
        left--;
      end
      guard++;
      wait_tick();
      compared++;
      if (current_angle !== 8'(m_current)) begin
        mismatched++;
        $display("FAIL %s current_angle: got %0d expected %0d", tag, current_angle, m_current);
      end
      compared++;
      if (busy !== 1'(m_current != m_target)) begin
        mismatched++;
        $display("FAIL %s busy: got %0b expected %0b", tag, busy, m_current != m_target);
      end
      measure_width(w);
      compared++;
      if (w != pulse_of(m_current)) begin
        mismatched++;
        $display("FAIL %s pulse_width: got %0d expected %0d", tag, w, pulse_of(m_current));
      end
    end
  endtask

  task automatic test_reset();
    int ticks;
    int first_tick;
    int last_tick;
    int gap;
    int highs;
    reset       = 1'b1;
    enable      = 1'b0;
    angle       = 8'd0;
    angle_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (servo_out !== 1'b0) begin
      mismatched++; $display("FAIL reset servo_out: got %0b expected 0", servo_out);
    end
    compared++;
    if (current_angle !== 8'(HOME)) begin
      mismatched++; $display("FAIL reset current_angle: got %0d expected %0d", current_angle, HOME);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL reset busy: got %0b expected 0", busy);
    end
    compared++;
    if (frame_tick !== 1'b0) begin
      mismatched++; $display("FAIL reset frame_tick: got %0b expected 0", frame_tick);
    end
    reset     = 1'b0;
    m_target  = HOME;
    m_current = HOME;
    ticks = 0; first_tick = -1; last_tick = -1; gap = -1; highs = 0;
    for (int i = 1; i <= 2 * FRAME + 10; i++) begin
      @(negedge clk);
      if (servo_out !== 1'b0) highs++;
      if (frame_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        else gap = i - last_tick;
        last_tick = i;
      end
    end
    compared++;
    if (first_tick != FRAME - 1) begin
      mismatched++; $display("FAIL idle first_tick: got cycle %0d expected %0d", first_tick, FRAME - 1);
    end
    compared++;
    if (ticks != 2 || gap != FRAME) begin
      mismatched++; $display("FAIL idle tick_period: got %0d ticks gap %0d expected 2 ticks gap %0d", ticks, gap, FRAME);
    end
    compared++;
    if (highs != 0) begin
      mismatched++; $display("FAIL idle no_pulses: got %0d high cycles expected 0", highs);
    end
    compared++;
    if (current_angle !== 8'(HOME) || busy !== 1'b0) begin
      mismatched++; $display("FAIL idle hold_home: got angle %0d busy %0b expected %0d 0", current_angle, busy, HOME);
    end
  endtask

  task automatic test_enable();
    int early_high;
    int rise1;
    int rise2;
    int width;
    bit prev;
    bit seen;
    repeat ($urandom_range(50, 300)) @(negedge clk);
    enable = 1'b1;
    early_high = 0;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      if (servo_out !== 1'b0) early_high++;
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    m_current = slew_ref(m_current, m_target);
    compared++;
    if (!seen || early_high != 0) begin
      mismatched++; $display("FAIL enable no_midframe_pulse: got tick %0b high %0d expected tick 1 high 0", seen, early_high);
    end
    rise1 = -1; rise2 = -1; width = 0; prev = 1'b0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (servo_out === 1'b1 && !prev) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      if (servo_out === 1'b1 && rise2 < 0) width++;
      prev = (servo_out === 1'b1);
    end
    compared++;
    if (rise1 != 1) begin
      mismatched++; $display("FAIL enable first_rise: got cycle %0d expected 1", rise1);
    end
    compared++;
    if (width != pulse_of(HOME)) begin
      mismatched++; $display("FAIL enable width: got %0d expected %0d", width, pulse_of(HOME));
    end
    compared++;
    if (rise2 - rise1 != FRAME) begin
      mismatched++; $display("FAIL enable period: got %0d expected %0d", rise2 - rise1, FRAME);
    end
  endtask

  task automatic test_ramp();
    strobe(m_current + $urandom_range(6, 20));
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL ramp busy_after_strobe: got %0b expected 1", busy);
    end
    run_ramp("ramp", 1);
  endtask

  task automatic test_coincident();
    int t2;
    bit seen;
    strobe(m_current + $urandom_range(8, 15));
    run_ramp("coinc_pre", 0);
    strobe(m_current + $urandom_range(8, 15));
    wait_tick();
    compared++;
    if (current_angle !== 8'(m_current)) begin
      mismatched++; $display("FAIL coinc first_step: got %0d expected %0d", current_angle, m_current);
    end
    t2 = m_current - $urandom_range(10, 20);
    seen = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    angle       = 8'(t2);
    angle_valid = 1'b1;
    @(posedge clk);
    #1;
    angle_valid = 1'b0;
    m_current = slew_ref(m_current, m_target);
    m_target  = t2;
    compared++;
    if (!seen || current_angle !== 8'(m_current)) begin
      mismatched++; $display("FAIL coinc old_target_step: got %0d tick %0b expected %0d tick 1", current_angle, seen, m_current);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL coinc busy: got %0b expected 1", busy);
    end
    run_ramp("coinc_post", 0);
  endtask

  task automatic test_clamp_up();
    strobe($urandom_range(181, 255));
    compared++;
    if (m_target != AMAX || busy !== 1'b1) begin
      mismatched++; $display("FAIL clamp busy: got %0b expected 1", busy);
    end
    run_ramp("clamp_up", 1);
  endtask

  task automatic test_disable();
    int w;
    int highs;
    wait_tick();
    w = 0;
    for (int i = 1; i <= FRAME - 10; i++) begin
      @(negedge clk);
      if (i == 150) enable = 1'b0;
      if (servo_out === 1'b1) w++;
    end
    compared++;
    if (w != pulse_of(m_current)) begin
      mismatched++; $display("FAIL disable full_width: got %0d expected %0d", w, pulse_of(m_current));
    end
    wait_tick();
    highs = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (servo_out !== 1'b0) highs++;
    end
    compared++;
    if (highs != 0) begin
      mismatched++; $display("FAIL disable stays_low: got %0d high cycles expected 0", highs);
    end
    // The two frames above were consumed without the model; angle is steady so only re-sync it.
    enable = 1'b1;
  endtask

  task automatic test_ramp_down();
    strobe(0);
    run_ramp("ramp_down", 2);
    compared++;
    if (current_angle !== 8'd0) begin
      mismatched++; $display("FAIL ramp_down floor: got %0d expected 0", current_angle);
    end
  endtask

  task automatic test_random();
    int w;
    for (int f = 0; f < 12; f++) begin
      wait_tick();
      compared++;
      if (current_angle !== 8'(m_current)) begin
        mismatched++; $display("FAIL random current_angle: got %0d expected %0d", current_angle, m_current);
      end
      compared++;
      if (busy !== 1'(m_current != m_target)) begin
        mismatched++; $display("FAIL random busy: got %0b expected %0b", busy, m_current != m_target);
      end
      measure_width(w);
      compared++;
      if (w != pulse_of(m_current)) begin
        mismatched++; $display("FAIL random pulse_width: got %0d expected %0d", w, pulse_of(m_current));
      end
      if ($urandom_range(0, 3) == 0) strobe(m_target);
      else if ($urandom_range(0, 2) != 0) strobe($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    wait_tick();
    repeat ($urandom_range(5, 30)) @(negedge clk);
    compared++;
    if (servo_out !== 1'b1) begin
      mismatched++; $display("FAIL rst_pulse in_pulse: got %0b expected 1", servo_out);
    end
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if (servo_out !== 1'b0) begin
      mismatched++; $display("FAIL rst_pulse async_drop: got %0b expected 0", servo_out);
    end
    compared++;
    if (current_angle !== 8'(HOME) || busy !== 1'b0) begin
      mismatched++; $display("FAIL rst_pulse home: got angle %0d busy %0b expected %0d 0", current_angle, busy, HOME);
    end
    @(negedge clk);
    reset     = 1'b0;
    m_target  = HOME;
    m_current = HOME;
    wait_tick();
    measure_width(w);
    compared++;
    if (w != pulse_of(HOME)) begin
      mismatched++; $display("FAIL rst_pulse resume_width: got %0d expected %0d", w, pulse_of(HOME));
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_ramp();
    test_coincident();
    test_clamp_up();
    test_disable();
    test_ramp_down();
    test_random();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
